// File: rtl/multipath_scan.sv
// Delay-path result selector: a manual switch-driven select path plus an autonomous
// scan engine that streams {channel, result, timeout} records over valid/ready.
module multipath_scan #(
  parameter int N_CH   = 32,
  parameter int RES_W  = 32,
  parameter int SEL_W  = $clog2(N_CH),
  parameter int TO_CYC = 4096,
  parameter int TO_W   = $clog2(TO_CYC)
) (
  input  logic                   clk250,
  input  logic                   rst_n,
  input  logic [N_CH*RES_W-1:0]  ch_result,
  input  logic [N_CH-1:0]        ch_fin,
  input  logic [SEL_W-1:0]       SW,
  input  logic                   mode,
  input  logic                   start,
  input  logic                   abort,
  output logic [RES_W-1:0]       result,
  output logic                   fin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SEL_W-1:0]       out_ch,
  output logic [RES_W-1:0]       out_data,
  output logic                   out_to,
  output logic                   busy,
  output logic                   done
);

  localparam int NPAD = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST    = SEL_W'(N_CH - 1);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TO_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT, S_DONE} st_t;

  typedef struct packed {
    logic [SEL_W-1:0] ch;
    logic [RES_W-1:0] data;
    logic             to;
  } rec_t;

  // Channels are padded to a power of two with zeros so an out-of-range SW reads 0.
  logic [NPAD-1:0][RES_W-1:0] res_arr;
  logic [NPAD-1:0]            fin_arr;

  for (genvar k = 0; k < NPAD; k++) begin : g_ch
    if (k < N_CH) begin : g_real
      assign res_arr[k] = ch_result[k*RES_W +: RES_W];
      assign fin_arr[k] = ch_fin[k];
    end else begin : g_pad
      assign res_arr[k] = '0;
      assign fin_arr[k] = 1'b0;
    end
  end

  logic [RES_W-1:0] result_q;
  logic             fin_q;

  always_ff @(posedge clk250 or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      fin_q    <= 1'b0;
    end else begin
      result_q <= res_arr[SW];
      fin_q    <= fin_arr[SW];
    end
  end

  st_t              st_q;
  rec_t             rec_q;
  logic             vld_q;
  logic             done_q;
  logic [SEL_W-1:0] idx_q;
  logic [TO_W-1:0]  tmr_q;

  always_ff @(posedge clk250 or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      rec_q  <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
      idx_q  <= '0;
      tmr_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        st_q  <= S_IDLE;
        vld_q <= 1'b0;
        idx_q <= '0;
        tmr_q <= '0;
      end else begin
        case (st_q)
          S_IDLE: if (start && mode) begin
            st_q  <= S_WAIT;
            idx_q <= '0;
            tmr_q <= '0;
          end
          S_WAIT: begin
            // fin wins over a timeout landing in the same cycle
            if (fin_arr[idx_q]) begin
              rec_q <= '{ch: idx_q, data: res_arr[idx_q], to: 1'b0};
              vld_q <= 1'b1;
              st_q  <= S_EMIT;
            end else if (tmr_q == TO_LAST) begin
              rec_q <= '{ch: idx_q, data: '1, to: 1'b1};
              vld_q <= 1'b1;
              st_q  <= S_EMIT;
            end else begin
              tmr_q <= tmr_q + 1'b1;
            end
          end
          S_EMIT: if (vld_q && out_ready) begin
            vld_q <= 1'b0;
            if (idx_q == LAST) begin
              st_q <= S_DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
              tmr_q <= '0;
              st_q  <= S_WAIT;
            end
          end
          S_DONE: begin
            done_q <= 1'b1;
            st_q   <= S_IDLE;
          end
          default: st_q <= S_IDLE;
        endcase
      end
    end
  end

  assign result    = result_q;
  assign fin       = fin_q;
  assign out_valid = vld_q;
  assign out_ch    = rec_q.ch;
  assign out_data  = rec_q.data;
  assign out_to    = rec_q.to;
  assign busy      = (st_q != S_IDLE);
  assign done      = done_q;

endmodule
